// File: rtl/button_event_pkg.sv
// Shared definitions for the button event classifier: state encoding and
// counter sizing.
package button_event_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    IDLE   = 3'd0,
    PRESS  = 3'd1,
    HELD   = 3'd2,
    WAIT   = 3'd3,
    PRESS2 = 3'd4
  } state_t;

  // Counter must hold the largest tick value with one bit of headroom.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) begin
      m = b;
    end else begin
      m = m;
    end
    if (c > m) begin
      m = c;
    end else begin
      m = m;
    end
    return $clog2(m) + 32'sd1;
  endfunction

endpackage

// File: rtl/level_edge.sv
// Registers the polarity-corrected button level and reports its rising and
// falling edges relative to the previous sample.
module level_edge (
  input  logic clk,
  input  logic rst,
  input  logic p,
  output logic rise,
  output logic fall
);

  logic prev_r;

  // Previous-sample register; cleared to "released" so a held button rises after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_r <= 1'b0;
    end else begin
      prev_r <= p;
    end
  end

  assign rise = p & ~prev_r;
  assign fall = ~p & prev_r;

endmodule

// File: rtl/button_event.sv
// Turns the debounced button level into single-cycle press, release, long,
// repeat, single-click and double-click events using one shared counter.
module button_event
  import button_event_pkg::*;
#(
  parameter bit ACTIVE_LOW   = 1'b0,
  parameter int LONG_TICKS   = 50_000_000,
  parameter int REPEAT_TICKS = 10_000_000,
  parameter int DOUBLE_TICKS = 15_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic debounced,
  output logic pressed,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_pulse,
  output logic repeat_pulse,
  output logic single_pulse,
  output logic double_pulse
);

  localparam int CW = cnt_width(LONG_TICKS, REPEAT_TICKS, DOUBLE_TICKS);
  localparam logic [CW-1:0] LONG_C = CW'(LONG_TICKS);
  localparam logic [CW-1:0] REP_C  = CW'(REPEAT_TICKS);
  localparam logic [CW-1:0] DBL_C  = CW'(DOUBLE_TICKS);
  localparam logic [CW-1:0] ONE_C  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] MAX_C  = {CW{1'b1}};
  localparam bit            REP_EN = (REPEAT_TICKS != 32'sd0);

  logic          p_s;
  logic          rise_s;
  logic          fall_s;
  logic [CW-1:0] cnt_inc_s;
  state_t        state_r;
  logic [CW-1:0] cnt_r;

  assign p_s       = debounced ^ ACTIVE_LOW;
  assign cnt_inc_s = (cnt_r == MAX_C) ? cnt_r : cnt_r + ONE_C;

  level_edge u_level_edge (
    .clk  (clk),
    .rst  (rst),
    .p    (p_s),
    .rise (rise_s),
    .fall (fall_s)
  );

  // Event FSM with shared saturating counter; every output is a register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= IDLE;
      cnt_r         <= {CW{1'b0}};
      pressed       <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_pulse    <= 1'b0;
      repeat_pulse  <= 1'b0;
      single_pulse  <= 1'b0;
      double_pulse  <= 1'b0;
    end else begin
      pressed       <= p_s;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_pulse    <= 1'b0;
      repeat_pulse  <= 1'b0;
      single_pulse  <= 1'b0;
      double_pulse  <= 1'b0;
      case (state_r)
        IDLE: begin
          if (rise_s) begin
            press_pulse <= 1'b1;
            state_r     <= PRESS;
            cnt_r       <= ONE_C;
          end
        end
        PRESS, PRESS2: begin
          // A release on the threshold edge still counts as a short click.
          if (fall_s && (cnt_r <= LONG_C)) begin
            release_pulse <= 1'b1;
            state_r       <= (state_r == PRESS) ? WAIT : IDLE;
            cnt_r         <= ONE_C;
          end else if (cnt_r == LONG_C) begin
            long_pulse <= 1'b1;
            state_r    <= HELD;
            cnt_r      <= ONE_C;
          end else begin
            cnt_r <= cnt_inc_s;
          end
        end
        HELD: begin
          if (fall_s) begin
            release_pulse <= 1'b1;
            state_r       <= IDLE;
            cnt_r         <= {CW{1'b0}};
          end else if (REP_EN && (cnt_r == REP_C)) begin
            repeat_pulse <= 1'b1;
            cnt_r        <= ONE_C;
          end else begin
            cnt_r <= cnt_inc_s;
          end
        end
        WAIT: begin
          // A second press on the window's last edge beats the single-click timeout.
          if (rise_s && (cnt_r <= DBL_C)) begin
            press_pulse  <= 1'b1;
            double_pulse <= 1'b1;
            state_r      <= PRESS2;
            cnt_r        <= ONE_C;
          end else if (cnt_r == DBL_C) begin
            single_pulse <= 1'b1;
            state_r      <= IDLE;
            cnt_r        <= {CW{1'b0}};
          end else begin
            cnt_r <= cnt_inc_s;
          end
        end
        default: begin
          state_r <= IDLE;
          cnt_r   <= {CW{1'b0}};
        end
      endcase
    end
  end

endmodule

// File: tb/tb_button_event.sv
// Self-checking bench for button_event: directed scenarios plus random
// press/release runs against a timestamp-based reference model.
module tb_button_event;

  localparam int L = 8;
  localparam int R = 4;
  localparam int D = 6;

  logic clk = 1'b0;
  logic rst;
  logic debounced;
  logic debounced_al;
  logic pressed, press_pulse, release_pulse, long_pulse, repeat_pulse, single_pulse, double_pulse;
  logic pressed_a, press_a, release_a, long_a, repeat_a, single_a, double_a;
  logic [6:0] obs, obs_al;

  int checks = 0;
  int errors = 0;

  // reference model state: edge index and event timestamps (-1 = none)
  int n, held_since, long_t, window_from;
  bit is_second, prevp;
  logic [6:0] exp_v;

  always #5 clk = ~clk;

  button_event #(.ACTIVE_LOW(1'b0), .LONG_TICKS(L), .REPEAT_TICKS(R), .DOUBLE_TICKS(D)) dut (
    .clk(clk), .rst(rst), .debounced(debounced), .pressed(pressed),
    .press_pulse(press_pulse), .release_pulse(release_pulse), .long_pulse(long_pulse),
    .repeat_pulse(repeat_pulse), .single_pulse(single_pulse), .double_pulse(double_pulse));

  button_event #(.ACTIVE_LOW(1'b1), .LONG_TICKS(L), .REPEAT_TICKS(R), .DOUBLE_TICKS(D)) dut_al (
    .clk(clk), .rst(rst), .debounced(debounced_al), .pressed(pressed_a),
    .press_pulse(press_a), .release_pulse(release_a), .long_pulse(long_a),
    .repeat_pulse(repeat_a), .single_pulse(single_a), .double_pulse(double_a));

  assign obs    = {pressed, press_pulse, release_pulse, long_pulse, repeat_pulse, single_pulse, double_pulse};
  assign obs_al = {pressed_a, press_a, release_a, long_a, repeat_a, single_a, double_a};

  task automatic model_reset();
    n = 0; held_since = -1; long_t = -1; window_from = -1;
    is_second = 1'b0; prevp = 1'b0; exp_v = 7'b0;
  endtask

  // Expected registered outputs for one clock edge, from the event timing rules.
  task automatic model_edge(input bit p);
    bit rise, fall;
    n = n + 1;
    rise = p & ~prevp;
    fall = ~p & prevp;
    prevp = p;
    exp_v = 7'b0;
    exp_v[6] = p;
    if (rise) begin
      exp_v[5] = 1'b1;
      if (window_from >= 0 && n - window_from <= D) begin
        exp_v[0] = 1'b1; is_second = 1'b1;
      end else begin
        is_second = 1'b0;
      end
      window_from = -1; held_since = n; long_t = -1;
    end else if (window_from >= 0 && n - window_from == D) begin
      exp_v[1] = 1'b1; window_from = -1;
    end
    if (fall && held_since >= 0) begin
      exp_v[4] = 1'b1;
      if (long_t < 0 && !is_second) window_from = n;
      held_since = -1; long_t = -1;
    end else if (p && !rise && held_since >= 0) begin
      if (long_t < 0 && n - held_since == L) begin
        exp_v[3] = 1'b1; long_t = n;
      end else if (long_t >= 0 && (n - long_t) % R == 0) begin
        exp_v[2] = 1'b1;
      end
    end
  endtask

  // Drive one cycle of button level (both polarities) and advance the model.
  task automatic step(input bit lvl);
    debounced = lvl;
    debounced_al = ~lvl;
    @(posedge clk);
    model_edge(lvl);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; debounced = 1'b0; debounced_al = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (obs !== 7'b0 || obs_al !== 7'b0) begin
      errors++; $display("FAIL reset_state: got=%b/%b exp=0000000", obs, obs_al);
    end
    rst = 1'b0;
  endtask

  task automatic test_short_click();
    int n_single, single_at, n_other;
    n_single = 0; single_at = -1; n_other = 0;
    for (int k = 0; k < 16; k++) begin
      step(k >= 2 && k < 5);
      checks++;
      if (obs !== exp_v || obs_al !== exp_v) begin
        errors++; $display("FAIL short_click k=%0d: got=%b/%b exp=%b", k, obs, obs_al, exp_v);
      end
      if (obs[1]) begin n_single++; single_at = k; end
      if (obs[3] | obs[2] | obs[0]) n_other++;
    end
    checks++;
    if (n_single != 1 || single_at != 5 + D || n_other != 0) begin
      errors++; $display("FAIL short_click_single: got count=%0d at=%0d other=%0d exp 1 at %0d other 0",
                         n_single, single_at, n_other, 5 + D);
    end
  endtask

  task automatic test_long_hold();
    int long_at, n_rep, n_rel, n_single;
    int rep_at[$];
    long_at = -1; n_rep = 0; n_rel = 0; n_single = 0;
    for (int k = 0; k < 32; k++) begin
      step(k >= 2 && k < 22);
      checks++;
      if (obs !== exp_v || obs_al !== exp_v) begin
        errors++; $display("FAIL long_hold k=%0d: got=%b/%b exp=%b", k, obs, obs_al, exp_v);
      end
      if (obs[3]) long_at = k;
      if (obs[2]) begin n_rep++; rep_at.push_back(k); end
      if (obs[4]) n_rel++;
      if (obs[1]) n_single++;
    end
    checks++;
    if (long_at != 2 + L || n_rep != 2 || n_rel != 1 || n_single != 0) begin
      errors++; $display("FAIL long_hold_events: got long_at=%0d reps=%0d rel=%0d single=%0d exp %0d 2 1 0",
                         long_at, n_rep, n_rel, n_single, 2 + L);
    end else begin
      checks++;
      if (rep_at[0] != 2 + L + R || rep_at[1] != 2 + L + 2 * R) begin
        errors++; $display("FAIL long_hold_repeat_times: got %0d,%0d exp %0d,%0d",
                           rep_at[0], rep_at[1], 2 + L + R, 2 + L + 2 * R);
      end
    end
  endtask

  // Two clicks separated by `gap` low cycles; gap D gives a double, D+1 a single.
  task automatic test_two_clicks(input int gap);
    int n_single, n_double, n_rel, n_press, dbl_at, coinc;
    int second;
    n_single = 0; n_double = 0; n_rel = 0; n_press = 0; dbl_at = -1; coinc = 0;
    second = 4 + gap;
    for (int k = 0; k < second + 14; k++) begin
      step((k >= 2 && k < 4) || (k >= second && k < second + 2));
      checks++;
      if (obs !== exp_v || obs_al !== exp_v) begin
        errors++; $display("FAIL two_clicks gap=%0d k=%0d: got=%b/%b exp=%b", gap, k, obs, obs_al, exp_v);
      end
      if (obs[1]) n_single++;
      if (obs[0]) begin n_double++; dbl_at = k; coinc = obs[5]; end
      if (obs[4]) n_rel++;
      if (obs[5]) n_press++;
    end
    checks++;
    if (gap <= D) begin
      if (n_double != 1 || dbl_at != second || coinc != 1 || n_rel != 2 || n_single != 0) begin
        errors++; $display("FAIL double_click: got dbl=%0d at=%0d coinc=%0d rel=%0d single=%0d exp 1 %0d 1 2 0",
                           n_double, dbl_at, coinc, n_rel, n_single, second);
      end
    end else begin
      if (n_double != 0 || n_single != 2 || n_press != 2) begin
        errors++; $display("FAIL gap_single: got dbl=%0d single=%0d press=%0d exp 0 2 2",
                           n_double, n_single, n_press);
      end
    end
  endtask

  task automatic test_release_at_long();
    int n_long, single_at;
    n_long = 0; single_at = -1;
    for (int k = 0; k < 20; k++) begin
      step(k >= 2 && k < 2 + L);
      checks++;
      if (obs !== exp_v || obs_al !== exp_v) begin
        errors++; $display("FAIL release_at_long k=%0d: got=%b/%b exp=%b", k, obs, obs_al, exp_v);
      end
      if (obs[3]) n_long++;
      if (obs[1]) single_at = k;
    end
    checks++;
    if (n_long != 0 || single_at != 2 + L + D) begin
      errors++; $display("FAIL release_at_long_events: got long=%0d single_at=%0d exp 0 %0d",
                         n_long, single_at, 2 + L + D);
    end
  endtask

  task automatic test_reset_mid();
    int n_single;
    n_single = 0;
    for (int k = 0; k < 7; k++) step(k >= 2 && k < 4);
    debounced = 1'b1; debounced_al = 1'b0;
    rst = 1'b1;
    model_reset();
    #1;
    checks++;
    if (obs !== 7'b0 || obs_al !== 7'b0) begin
      errors++; $display("FAIL reset_async: got=%b/%b exp=0000000", obs, obs_al);
    end
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    step(1'b1);
    checks++;
    if (press_pulse !== 1'b1 || press_a !== 1'b1) begin
      errors++; $display("FAIL reset_held_press: got=%b/%b exp=1", press_pulse, press_a);
    end
    for (int k = 0; k < 6; k++) begin
      step(k < 2);
      checks++;
      if (obs !== exp_v || obs_al !== exp_v) begin
        errors++; $display("FAIL reset_mid k=%0d: got=%b/%b exp=%b", k, obs, obs_al, exp_v);
      end
      if (obs[1]) n_single++;
    end
    checks++;
    if (n_single != 0) begin
      errors++; $display("FAIL reset_no_stale_single: got=%0d exp=0", n_single);
    end
    for (int k = 0; k < 12; k++) step(1'b0);
  endtask

  task automatic test_polarity();
    int press_at, rel_at, single_at;
    press_at = -1; rel_at = -1; single_at = -1;
    for (int k = 0; k < 16; k++) begin
      step(k >= 2 && k < 5);
      if (press_a) press_at = k;
      if (release_a) rel_at = k;
      if (single_a) single_at = k;
    end
    checks++;
    if (press_at != 2 || rel_at != 5 || single_at != 5 + D) begin
      errors++; $display("FAIL polarity: got press=%0d rel=%0d single=%0d exp 2 5 %0d",
                         press_at, rel_at, single_at, 5 + D);
    end
  endtask

  task automatic test_random();
    bit lvl;
    int run;
    lvl = 1'b0;
    for (int r = 0; r < 60; r++) begin
      run = $urandom_range(1, 14);
      for (int k = 0; k < run; k++) begin
        step(lvl);
        checks++;
        if (obs !== exp_v || obs_al !== exp_v) begin
          errors++; $display("FAIL random r=%0d k=%0d: got=%b/%b exp=%b", r, k, obs, obs_al, exp_v);
        end
      end
      lvl = ~lvl;
    end
  endtask

  initial begin
    test_reset();
    test_short_click();
    test_long_hold();
    test_two_clicks(D);
    test_release_at_long();
    test_two_clicks(D + 1);
    test_reset_mid();
    test_polarity();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
